// File: rtl/floo_axis_chan_sched.sv
// Two-channel (request/response) scheduler onto a single AXI-Stream link.
// Each channel is credit-flow-controlled against the far-side buffer. A
// round-robin pointer arbitrates between eligible channels. The winning flit
// is loaded into one output register, with a header bit prepended.
module floo_axis_chan_sched #(
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned NumCredits = 8,
   localparam int unsigned CntWidth  = $clog2(NumCredits + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [DataWidth-1:0] req_data_i,
   input  logic                 rsp_valid_i,
   output logic                 rsp_ready_o,
   input  logic [DataWidth-1:0] rsp_data_i,
   input  logic                 credit_req_i,
   input  logic                 credit_rsp_i,
   output logic                 axis_tvalid_o,
   input  logic                 axis_tready_i,
   output logic [DataWidth:0]   axis_tdata_o,
   output logic [CntWidth-1:0]  credits_req_o,
   output logic [CntWidth-1:0]  credits_rsp_o,
   output logic                 err_o
);

   typedef enum logic {
      PRIO_REQ = 1'b0,
      PRIO_RSP = 1'b1
   } prio_e;

   localparam logic [CntWidth-1:0] MaxCred = CntWidth'(NumCredits);

   prio_e               prio_q;
   logic                load_en;
   logic                elig_req, elig_rsp;
   logic                grant_req, grant_rsp;
   logic [CntWidth-1:0] cred_req_d, cred_rsp_d;
   logic                ovf_req, ovf_rsp;

   // Arbitration and ready generation; readies are forced low during reset
   // so that valids presented while in reset are never accepted.
   always_comb begin
      load_en     = !axis_tvalid_o || axis_tready_i;
      elig_req    = req_valid_i && (credits_req_o != '0);
      elig_rsp    = rsp_valid_i && (credits_rsp_o != '0);
      grant_req   = elig_req && (!elig_rsp || (prio_q == PRIO_REQ));
      grant_rsp   = elig_rsp && (!elig_req || (prio_q == PRIO_RSP));
      req_ready_o = !rst_i && load_en && grant_req;
      rsp_ready_o = !rst_i && load_en && grant_rsp;
   end

   // Next credit values; a simultaneous return and consume cancel out.
   always_comb begin
      cred_req_d = credits_req_o;
      ovf_req    = 1'b0;
      if (credit_req_i && !req_ready_o) begin
         if (credits_req_o == MaxCred) ovf_req = 1'b1;
         else                          cred_req_d = credits_req_o + CntWidth'(1);
      end else if (req_ready_o && !credit_req_i) begin
         cred_req_d = credits_req_o - CntWidth'(1);
      end

      cred_rsp_d = credits_rsp_o;
      ovf_rsp    = 1'b0;
      if (credit_rsp_i && !rsp_ready_o) begin
         if (credits_rsp_o == MaxCred) ovf_rsp = 1'b1;
         else                          cred_rsp_d = credits_rsp_o + CntWidth'(1);
      end else if (rsp_ready_o && !credit_rsp_i) begin
         cred_rsp_d = credits_rsp_o - CntWidth'(1);
      end
   end

   // Credit counters and sticky overflow flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         credits_req_o <= MaxCred;
         credits_rsp_o <= MaxCred;
         err_o         <= 1'b0;
      end else begin
         credits_req_o <= cred_req_d;
         credits_rsp_o <= cred_rsp_d;
         if (ovf_req || ovf_rsp) err_o <= 1'b1;
      end
   end

   // Round-robin pointer: after a grant, the other channel gets priority.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q <= PRIO_REQ;
      end else if (req_ready_o) begin
         prio_q <= PRIO_RSP;
      end else if (rsp_ready_o) begin
         prio_q <= PRIO_REQ;
      end
   end

   // Output beat register. Data holds its value when the register drains empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         axis_tvalid_o <= 1'b0;
         axis_tdata_o  <= '0;
      end else if (load_en) begin
         axis_tvalid_o <= req_ready_o || rsp_ready_o;
         if (req_ready_o)      axis_tdata_o <= {1'b0, req_data_i};
         else if (rsp_ready_o) axis_tdata_o <= {1'b1, rsp_data_i};
      end
   end

endmodule

// File: tb/tb_floo_axis_chan_sched.sv
// Directed bench for floo_axis_chan_sched with NumCredits=4 and DataWidth=64.
module tb_floo_axis_chan_sched;

   localparam int unsigned DW = 64;
   localparam int unsigned NC = 4;
   localparam int unsigned CW = $clog2(NC + 1);

   localparam logic [DW-1:0] DA = 64'hA5A5_0000_1111_2222;
   localparam logic [DW-1:0] DB = 64'h5A5A_3333_4444_5555;
   localparam logic [DW-1:0] DC = 64'hC3C3_6666_7777_8888;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0, rsp_valid = 1'b0;
   logic          req_ready, rsp_ready;
   logic [DW-1:0] req_data = '0, rsp_data = '0;
   logic          credit_req = 1'b0, credit_rsp = 1'b0;
   logic          tvalid;
   logic          tready = 1'b0;
   logic [DW:0]   tdata;
   logic [CW-1:0] cred_req, cred_rsp;
   logic          err;

   int total = 0;
   int bad   = 0;

   floo_axis_chan_sched #(
      .DataWidth (DW),
      .NumCredits(NC)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_data_i   (req_data),
      .rsp_valid_i  (rsp_valid),
      .rsp_ready_o  (rsp_ready),
      .rsp_data_i   (rsp_data),
      .credit_req_i (credit_req),
      .credit_rsp_i (credit_rsp),
      .axis_tvalid_o(tvalid),
      .axis_tready_i(tready),
      .axis_tdata_o (tdata),
      .credits_req_o(cred_req),
      .credits_rsp_o(cred_rsp),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid  = 1'b0;
      rsp_valid  = 1'b0;
      credit_req = 1'b0;
      credit_rsp = 1'b0;
      tready     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1; rsp_valid = 1'b1;
      credit_req = 1'b1; credit_rsp = 1'b1;
      tready = 1'b1;
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
      total++; if (rsp_ready !== 1'b0) begin bad++; $display("FAIL rst_rsp_ready got=%b exp=0", rsp_ready); end
      step(); step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", tvalid); end
      total++; if (tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", tdata); end
      total++; if (cred_req !== CW'(NC)) begin bad++; $display("FAIL rst_cred_req got=%0d exp=%0d", cred_req, NC); end
      total++; if (cred_rsp !== CW'(NC)) begin bad++; $display("FAIL rst_cred_rsp got=%0d exp=%0d", cred_rsp, NC); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      clear_inputs();
      rst = 1'b0;
      step();
      total++; if (cred_req !== CW'(NC) || err !== 1'b0 || tvalid !== 1'b0) begin
         bad++; $display("FAIL rst_release cred_req=%0d err=%b tvalid=%b exp 4/0/0", cred_req, err, tvalid);
      end
   endtask

   // (a) both channels streaming: strict alternation until both run dry
   task automatic test_alternate();
      logic [DW:0] exp;
      do_reset();
      req_data = DA; rsp_data = DB;
      req_valid = 1'b1; rsp_valid = 1'b1; tready = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1 || rsp_ready !== 1'b0) begin
         bad++; $display("FAIL alt_first_grant req=%b rsp=%b exp 1/0", req_ready, rsp_ready);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         exp = (k % 2 == 1) ? {1'b1, DB} : {1'b0, DA};
         total++; if (tvalid !== 1'b1 || tdata !== exp) begin
            bad++; $display("FAIL alt_beat%0d tvalid=%b tdata=%h exp 1/%h", k, tvalid, tdata, exp);
         end
      end
      total++; if (req_ready !== 1'b0 || rsp_ready !== 1'b0) begin
         bad++; $display("FAIL alt_dry_ready req=%b rsp=%b exp 0/0", req_ready, rsp_ready);
      end
      total++; if (cred_req !== '0 || cred_rsp !== '0) begin
         bad++; $display("FAIL alt_dry_cred req=%0d rsp=%0d exp 0/0", cred_req, cred_rsp);
      end
      step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL alt_drop_tvalid got=%b exp=0", tvalid); end
      clear_inputs();
   endtask

   // (b) req only: four beats, stall, then one credit return re-enables it
   task automatic test_credit_return();
      do_reset();
      req_data = DA;
      req_valid = 1'b1; tready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         total++; if (tvalid !== 1'b1 || tdata !== {1'b0, DA} || cred_req !== CW'(3 - k)) begin
            bad++; $display("FAIL b2b_beat%0d tvalid=%b tdata=%h cred=%0d exp 1/%h/%0d", k, tvalid, tdata, cred_req, {1'b0, DA}, 3 - k);
         end
      end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b exp=0", req_ready); end
      step();
      total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL b2b_stall_tvalid got=%b exp=0", tvalid); end
      step();
      credit_req = 1'b1;
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL cret_same_cycle_ready got=%b exp=0", req_ready); end
      step();
      credit_req = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1 || tvalid !== 1'b0 || cred_req !== CW'(1)) begin
         bad++; $display("FAIL cret_next_cycle ready=%b tvalid=%b cred=%0d exp 1/0/1", req_ready, tvalid, cred_req);
      end
      step();
      total++; if (tvalid !== 1'b1 || tdata !== {1'b0, DA}) begin
         bad++; $display("FAIL cret_beat tvalid=%b tdata=%h exp 1/%h", tvalid, tdata, {1'b0, DA});
      end
      clear_inputs();
      step();
   endtask

   // (c) backpressure holds the beat; release accepts and reloads at once
   task automatic test_backpressure();
      do_reset();
      req_data = DA; rsp_data = DC;
      req_valid = 1'b1; tready = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_empty_ready got=%b exp=1", req_ready); end
      step();
      req_data = DB;
      rsp_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         #1;
         total++; if (tvalid !== 1'b1 || tdata !== {1'b0, DA} || req_ready !== 1'b0 || rsp_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold%0d tvalid=%b tdata=%h rdy=%b%b exp 1/%h/00", i, tvalid, tdata, req_ready, rsp_ready, {1'b0, DA});
         end
      end
      tready = 1'b1;
      #1;
      total++; if (rsp_ready !== 1'b1 || req_ready !== 1'b0) begin
         bad++; $display("FAIL bp_release_grant req=%b rsp=%b exp 0/1", req_ready, rsp_ready);
      end
      step();
      total++; if (tvalid !== 1'b1 || tdata !== {1'b1, DC}) begin
         bad++; $display("FAIL bp_next_beat tvalid=%b tdata=%h exp 1/%h", tvalid, tdata, {1'b1, DC});
      end
      clear_inputs();
      step();
   endtask

   // (d) return and consume in the same cycle leave the count unchanged
   task automatic test_credit_cancel();
      do_reset();
      req_data = DA;
      req_valid = 1'b1; tready = 1'b1;
      step(); step();
      total++; if (cred_req !== CW'(2) || req_ready !== 1'b1) begin
         bad++; $display("FAIL cancel_pre cred=%0d ready=%b exp 2/1", cred_req, req_ready);
      end
      credit_req = 1'b1;
      step();
      credit_req = 1'b0;
      req_valid = 1'b0;
      total++; if (cred_req !== CW'(2) || err !== 1'b0) begin
         bad++; $display("FAIL cancel_cred cred=%0d err=%b exp 2/0", cred_req, err);
      end
      clear_inputs();
      step();
   endtask

   // (e) return at full credits saturates and sets the sticky error
   task automatic test_overflow();
      do_reset();
      credit_rsp = 1'b1;
      step();
      credit_rsp = 1'b0;
      total++; if (cred_rsp !== CW'(NC) || err !== 1'b1) begin
         bad++; $display("FAIL ovf_sat cred=%0d err=%b exp 4/1", cred_rsp, err);
      end
      repeat (3) step();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", err); end
      rst = 1'b1;
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", err); end
      step();
      rst = 1'b0;
   endtask

   // (f) asynchronous reset mid-stream drops the beat and restores priority
   task automatic test_reset_midstream();
      do_reset();
      req_data = DA; rsp_data = DB;
      req_valid = 1'b1; rsp_valid = 1'b1; tready = 1'b1;
      step(); step(); step();
      total++; if (tvalid !== 1'b1 || tdata !== {1'b0, DA}) begin
         bad++; $display("FAIL mid_pre tvalid=%b tdata=%h exp 1/%h", tvalid, tdata, {1'b0, DA});
      end
      #2;
      rst = 1'b1;
      #1;
      total++; if (tvalid !== 1'b0 || cred_req !== CW'(NC) || cred_rsp !== CW'(NC)) begin
         bad++; $display("FAIL mid_async tvalid=%b cred=%0d/%0d exp 0/4/4", tvalid, cred_req, cred_rsp);
      end
      total++; if (req_ready !== 1'b0 || rsp_ready !== 1'b0) begin
         bad++; $display("FAIL mid_ready req=%b rsp=%b exp 0/0", req_ready, rsp_ready);
      end
      step();
      rst = 1'b0;
      #1;
      total++; if (tvalid !== 1'b0 || req_ready !== 1'b1 || rsp_ready !== 1'b0) begin
         bad++; $display("FAIL mid_release tvalid=%b req=%b rsp=%b exp 0/1/0", tvalid, req_ready, rsp_ready);
      end
      step();
      total++; if (tvalid !== 1'b1 || tdata !== {1'b0, DA}) begin
         bad++; $display("FAIL mid_first_beat tvalid=%b tdata=%h exp 1/%h", tvalid, tdata, {1'b0, DA});
      end
      clear_inputs();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alternate();
      test_credit_return();
      test_backpressure();
      test_credit_cancel();
      test_overflow();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
